// File: rtl/core_pkg.sv
// Shared core types and constants for machine-mode trap sequencing.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_t;

  typedef enum logic [1:0] {
    EXC  = 2'd0,
    IRQ  = 2'd1,
    MRET = 2'd2
  } trap_kind_t;

  localparam int          MCAUSE_IRQ_BIT      = 31;
  localparam int          IRQ_CAUSE_MEXT      = 11;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

  localparam logic [4:0]  EXC_ILLEGAL_INSTR   = 5'd2;
  localparam logic [4:0]  EXC_LOAD_MISALIGNED = 5'd4;
  localparam logic [4:0]  EXC_ECALL_M         = 5'd11;

  localparam logic [31:0] MCAUSE_IRQ_MEXT =
    (32'd1 << MCAUSE_IRQ_BIT) | 32'(IRQ_CAUSE_MEXT);
  localparam logic [31:0] VEC_OFFSET_MEXT = 32'(4 * IRQ_CAUSE_MEXT);

endpackage

// File: rtl/trap_ctrl.sv
// Trap entry / MRET sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
// Build option TRAP_CTRL_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl
  import core_pkg::*;
#(
  parameter int DRAIN_MAX = 15,
  parameter int CAUSE_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               exc_req_i,
  input  logic [CAUSE_W-1:0] exc_cause_i,
  input  logic [31:0]        exc_pc_i,
  input  logic [31:0]        exc_tval_i,
  input  logic               mret_i,
  input  logic               irq_i,
  input  logic [31:0]        irq_pc_i,
  input  logic               pipe_idle_i,
  input  logic [31:0]        mtvec_i,
  input  logic [31:0]        mepc_i,
  input  logic               mstatus_mie_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               csr_trap_we_o,
  output logic               csr_mret_o,
  output logic [31:0]        csr_mepc_o,
  output logic [31:0]        csr_mcause_o,
  output logic [31:0]        csr_mtval_o,
  output logic               pc_redirect_o,
  output logic [31:0]        pc_target_o,
  output logic               busy_o,
  output logic               drain_timeout_o
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  trap_state_t      state, state_nxt;
  trap_kind_t       kind;
  logic [CNT_W-1:0] drain_cnt;
  logic             take_exc, take_mret, take_irq, accept;
  logic             hit_max;

  function automatic logic [31:0] trap_target(input trap_kind_t k, input logic [31:0] tvec);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
    if (k == IRQ && tvec[1:0] == MTVEC_MODE_VECTORED)
      return base + VEC_OFFSET_MEXT;
`endif
    return base;
  endfunction

`ifndef TRAP_CTRL_VECTORED_EN
  logic unused_mode;
  assign unused_mode = ^mtvec_i[1:0];
`endif

  // exc > mret > irq; interrupts gated by MIE
  assign take_exc  = exc_req_i;
  assign take_mret = mret_i & ~exc_req_i;
  assign take_irq  = irq_i & mstatus_mie_i & ~exc_req_i & ~mret_i;
  assign accept    = (state == IDLE) & (take_exc | take_mret | take_irq);
  assign hit_max   = (drain_cnt == CNT_W'(DRAIN_MAX));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = DRAIN;
      DRAIN:    if (pipe_idle_i || hit_max) state_nxt = COMMIT;
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      kind            <= EXC;
      drain_cnt       <= '0;
      drain_timeout_o <= 1'b0;
      csr_mepc_o      <= '0;
      csr_mcause_o    <= '0;
      csr_mtval_o     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (take_exc) begin
          kind         <= EXC;
          csr_mepc_o   <= {exc_pc_i[31:1], 1'b0};
          csr_mcause_o <= {{(32-CAUSE_W){1'b0}}, exc_cause_i};
          csr_mtval_o  <= exc_tval_i;
        end else if (take_mret) begin
          kind <= MRET;
        end else begin
          kind         <= IRQ;
          csr_mepc_o   <= irq_pc_i;
          csr_mcause_o <= MCAUSE_IRQ_MEXT;
          csr_mtval_o  <= '0;
        end
      end
      if (state == DRAIN && state_nxt == DRAIN)
        drain_cnt <= drain_cnt + CNT_W'(1);
      else
        drain_cnt <= '0;
      if (state == DRAIN && hit_max && !pipe_idle_i)
        drain_timeout_o <= 1'b1;
    end
  end

  // Control outputs decode straight from state so reset clears them at once
  assign busy_o        = (state != IDLE);
  assign stall_o       = (state != IDLE);
  assign flush_o       = (state == DRAIN);
  assign csr_trap_we_o = (state == COMMIT) && (kind != MRET);
  assign csr_mret_o    = (state == COMMIT) && (kind == MRET);
  assign pc_redirect_o = (state == REDIRECT);
  assign pc_target_o   = (state != REDIRECT) ? 32'd0 :
                         (kind == MRET)      ? mepc_i : trap_target(kind, mtvec_i);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, MRET, priority, IRQ gating/vectoring,
// drain timeout and asynchronous reset mid-sequence.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, irq;
  logic [31:0] irq_pc;
  logic        pipe_idle;
  logic [31:0] mtvec, mepc;
  logic        mie;
  logic        stall, flush, csr_trap_we, csr_mret;
  logic [31:0] csr_mepc, csr_mcause, csr_mtval;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy, drain_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  trap_ctrl #(.DRAIN_MAX(15), .CAUSE_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
    .mret_i(mret), .irq_i(irq), .irq_pc_i(irq_pc), .pipe_idle_i(pipe_idle),
    .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_mie_i(mie),
    .stall_o(stall), .flush_o(flush), .csr_trap_we_o(csr_trap_we), .csr_mret_o(csr_mret),
    .csr_mepc_o(csr_mepc), .csr_mcause_o(csr_mcause), .csr_mtval_o(csr_mtval),
    .pc_redirect_o(pc_redirect), .pc_target_o(pc_target),
    .busy_o(busy), .drain_timeout_o(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    exc_req = 1'b0;
    mret    = 1'b0;
    irq     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] vec_target;
    rst_n = 1'b0; clear_reqs();
    exc_cause = '0; exc_pc = '0; exc_tval = '0; irq_pc = '0;
    pipe_idle = 1'b1; mtvec = 32'h0000_0100; mepc = '0; mie = 1'b0;
    #23;
    // reset state
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_stall",   {31'd0, stall}, 32'd0);
    chk("rst_flush",   {31'd0, flush}, 32'd0);
    chk("rst_trap_we", {31'd0, csr_trap_we}, 32'd0);
    chk("rst_mepc",    csr_mepc, 32'd0);
    chk("rst_target",  pc_target, 32'd0);
    chk("rst_timeout", {31'd0, drain_timeout}, 32'd0);
    tick(); rst_n = 1'b1; tick();

    // exception path
    exc_req = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_0104; exc_tval = 32'hDEAD_BEEF;
    tick(); clear_reqs();
    chk("exc_drain_busy",  {31'd0, busy}, 32'd1);
    chk("exc_drain_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("exc_we",     {31'd0, csr_trap_we}, 32'd1);
    chk("exc_mret",   {31'd0, csr_mret}, 32'd0);
    chk("exc_stall",  {31'd0, stall}, 32'd1);
    chk("exc_mepc",   csr_mepc, 32'h0000_0104);
    chk("exc_mcause", csr_mcause, 32'd2);
    chk("exc_mtval",  csr_mtval, 32'hDEAD_BEEF);
    tick();
    chk("exc_redir",  {31'd0, pc_redirect}, 32'd1);
    chk("exc_target", pc_target, 32'h0000_0100);
    chk("exc_we_off", {31'd0, csr_trap_we}, 32'd0);
    tick();
    chk("exc_idle",   {31'd0, busy}, 32'd0);

    // MRET
    mret = 1'b1; mepc = 32'h0000_0200;
    tick(); clear_reqs();
    tick();
    chk("mret_pulse", {31'd0, csr_mret}, 32'd1);
    chk("mret_no_we", {31'd0, csr_trap_we}, 32'd0);
    tick();
    chk("mret_redir",  {31'd0, pc_redirect}, 32'd1);
    chk("mret_target", pc_target, 32'h0000_0200);
    tick();
    chk("mret_idle",   {31'd0, busy}, 32'd0);

    // coincident requests: exception wins
    exc_req = 1'b1; mret = 1'b1; irq = 1'b1; mie = 1'b1;
    exc_cause = 5'd11; exc_pc = 32'h0000_0301; exc_tval = 32'h0000_1234; irq_pc = 32'h0000_0500;
    tick(); clear_reqs();
    tick();
    chk("pri_we",     {31'd0, csr_trap_we}, 32'd1);
    chk("pri_mret",   {31'd0, csr_mret}, 32'd0);
    chk("pri_mcause", csr_mcause, 32'd11);
    chk("pri_mepc",   csr_mepc, 32'h0000_0300);
    tick();
    chk("pri_target", pc_target, 32'h0000_0100);
    tick(); tick();
    chk("pri_single", {31'd0, busy}, 32'd0);

    // interrupt gated by MIE
    mie = 1'b0; irq = 1'b1; irq_pc = 32'h0000_0400;
    tick(); tick();
    chk("irq_gated", {31'd0, busy}, 32'd0);
    mie = 1'b1; mtvec = 32'h0000_0101;
    tick(); clear_reqs();
    chk("irq_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("irq_we",     {31'd0, csr_trap_we}, 32'd1);
    chk("irq_mcause", csr_mcause, 32'h8000_000B);
    chk("irq_mepc",   csr_mepc, 32'h0000_0400);
    chk("irq_mtval",  csr_mtval, 32'd0);
    tick();
`ifdef TRAP_CTRL_VECTORED_EN
    vec_target = 32'h0000_012C;
`else
    vec_target = 32'h0000_0100;
`endif
    chk("irq_target", pc_target, vec_target);
    tick();
    mtvec = 32'h0000_0100;

    // drain timeout with pipeline never idle
    pipe_idle = 1'b0; exc_req = 1'b1; exc_cause = 5'd4; exc_pc = 32'h0000_0600; exc_tval = 32'h0000_0601;
    tick(); clear_reqs();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_flush%0d", i), {31'd0, flush & stall}, 32'd1);
      tick();
    end
    chk("to_commit",  {31'd0, csr_trap_we}, 32'd1);
    chk("to_flag",    {31'd0, drain_timeout}, 32'd1);
    chk("to_noflush", {31'd0, flush}, 32'd0);
    tick(); tick();
    pipe_idle = 1'b1;
    tick();
    chk("to_sticky",  {31'd0, drain_timeout}, 32'd1);
    chk("to_idle",    {31'd0, busy}, 32'd0);

    // reset during DRAIN
    pipe_idle = 1'b0; exc_req = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_0700;
    tick(); clear_reqs(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",    {31'd0, busy}, 32'd0);
    chk("mrst_flush",   {31'd0, flush}, 32'd0);
    chk("mrst_timeout", {31'd0, drain_timeout}, 32'd0);
    chk("mrst_mepc",    csr_mepc, 32'd0);
    tick(); rst_n = 1'b1; pipe_idle = 1'b1; tick();
    exc_req = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_0800; exc_tval = 32'h0000_00AA;
    tick(); clear_reqs(); tick();
    chk("post_we",   {31'd0, csr_trap_we}, 32'd1);
    chk("post_mepc", csr_mepc, 32'h0000_0800);
    tick();
    chk("post_target", pc_target, 32'h0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
